frame_bus: RTL and testbench



---
 rtl/frame_bus.sv | 233 +++++++++++++++++++++++
 tb/tb_frame_bus.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_bus.sv
// Pixel buffering bus: write FIFO -> frame memory -> read FIFO, with a small
// controller that stores incoming words and replays them on a read_init edge.
module frame_bus #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 256,
    parameter int MEM_DEPTH  = 1024,
    localparam int FAW       = $clog2(FIFO_DEPTH),
    localparam int CW        = FAW + 1,
    localparam int AW        = $clog2(MEM_DEPTH),
    localparam int NW        = AW + 1
) (
    input  logic              ctrl_clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] iData,
    input  logic              iValid,
    input  logic              read_init,
    output logic [DATA_W-1:0] oData,
    output logic              oValid,
    output logic              read_empty_rdfifo,
    output logic              write_full_wrfifo,
    output logic [CW-1:0]     write_fifo_wrusedw,
    output logic [CW-1:0]     write_fifo_rdusedw,
    output logic [CW-1:0]     read_fifo_wrusedw,
    output logic [CW-1:0]     read_fifo_rdusedw
);

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_W-1:0] r_wf_mem [FIFO_DEPTH];
    logic [FAW-1:0]    r_wf_wptr;
    logic [FAW-1:0]    r_wf_rptr;
    logic [CW-1:0]     r_wf_cnt;
    logic              w_wf_full;
    logic              w_wf_empty;
    logic              w_wf_push;
    logic              w_wf_pop;
    logic [DATA_W-1:0] w_wf_q;

    logic [DATA_W-1:0] r_rf_mem [FIFO_DEPTH];
    logic [FAW-1:0]    r_rf_wptr;
    logic [FAW-1:0]    r_rf_rptr;
    logic [CW-1:0]     r_rf_cnt;
    logic              w_rf_empty;
    logic              w_rf_push;
    logic              w_rf_pop;
    logic [DATA_W-1:0] w_rf_q;
    logic [CW:0]       w_rf_occ;
    logic              w_rf_room;

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];
    logic [DATA_W-1:0] r_mem_q_p1;
    logic              r_rd_vld_p1;
    logic [AW-1:0]     r_wr_addr;
    logic [NW-1:0]     r_wr_count;
    logic [NW-1:0]     r_len;
    logic [NW-1:0]     r_issued;
    logic [AW-1:0]     w_rd_addr;
    logic              w_rd_en;
    logic              w_enter_read;

    logic              r_init_d;
    logic              r_pending;
    logic              w_init_rise;

    logic [DATA_W-1:0] r_odata;
    logic              r_ovalid;

    assign w_wf_full  = (r_wf_cnt == CW'(FIFO_DEPTH));
    assign w_wf_empty = (r_wf_cnt == '0);
    assign w_wf_push  = iValid && !w_wf_full;
    assign w_wf_q     = r_wf_mem[r_wf_rptr];

    assign w_rf_empty = (r_rf_cnt == '0);
    assign w_rf_push  = r_rd_vld_p1;
    assign w_rf_pop   = !w_rf_empty;
    assign w_rf_q     = r_rf_mem[r_rf_rptr];
    // Reads still in the RAM pipeline must be counted against read-FIFO space
    assign w_rf_occ   = {1'b0, r_rf_cnt} + {{CW{1'b0}}, r_rd_vld_p1};
    assign w_rf_room  = (w_rf_occ < (CW+1)'(FIFO_DEPTH));

    assign w_rd_addr   = r_issued[AW-1:0];
    assign w_init_rise = read_init && !r_init_d;

    always_ff @(posedge ctrl_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_wf_empty)
                    w_state_nxt = ST_WRITE;
                else if (r_pending)
                    w_state_nxt = ST_READ;
            end
            ST_WRITE: begin
                if (w_wf_empty)
                    w_state_nxt = ST_IDLE;
            end
            ST_READ: begin
                if ((r_issued == r_len) && !r_rd_vld_p1)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_wf_pop     = (r_state == ST_WRITE) && !w_wf_empty;
        w_rd_en      = (r_state == ST_READ) && (r_issued != r_len) && w_rf_room;
        w_enter_read = (r_state == ST_IDLE) && w_wf_empty && r_pending;
    end

    always_ff @(posedge ctrl_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_init_d  <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_init_d <= read_init;
            if (w_enter_read)
                r_pending <= 1'b0;
            else if (w_init_rise && (r_state != ST_READ))
                r_pending <= 1'b1;
        end
    end

    always_ff @(posedge ctrl_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wf_wptr <= '0;
            r_wf_rptr <= '0;
            r_wf_cnt  <= '0;
        end else begin
            if (w_wf_push)
                r_wf_wptr <= r_wf_wptr + FAW'(1);
            if (w_wf_pop)
                r_wf_rptr <= r_wf_rptr + FAW'(1);
            case ({w_wf_push, w_wf_pop})
                2'b10:   r_wf_cnt <= r_wf_cnt + CW'(1);
                2'b01:   r_wf_cnt <= r_wf_cnt - CW'(1);
                default: r_wf_cnt <= r_wf_cnt;
            endcase
        end
    end

    always_ff @(posedge ctrl_clk) begin
        if (w_wf_push)
            r_wf_mem[r_wf_wptr] <= iData;
    end

    always_ff @(posedge ctrl_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_addr   <= '0;
            r_wr_count  <= '0;
            r_len       <= '0;
            r_issued    <= '0;
            r_rd_vld_p1 <= 1'b0;
        end else begin
            r_rd_vld_p1 <= w_rd_en;
            if (w_wf_pop) begin
                r_wr_addr <= (r_wr_addr == AW'(MEM_DEPTH - 1)) ? '0 : r_wr_addr + AW'(1);
                if (r_wr_count != NW'(MEM_DEPTH))
                    r_wr_count <= r_wr_count + NW'(1);
            end
            if (w_enter_read) begin
                r_len    <= r_wr_count;
                r_issued <= '0;
            end else if (w_rd_en) begin
                r_issued <= r_issued + NW'(1);
            end
        end
    end

    // ---- stage p1: frame memory, one-cycle synchronous read ----
    always_ff @(posedge ctrl_clk) begin
        if (w_wf_pop)
            r_mem[r_wr_addr] <= w_wf_q;
        if (w_rd_en)
            r_mem_q_p1 <= r_mem[w_rd_addr];
    end

    always_ff @(posedge ctrl_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rf_wptr <= '0;
            r_rf_rptr <= '0;
            r_rf_cnt  <= '0;
        end else begin
            if (w_rf_push)
                r_rf_wptr <= r_rf_wptr + FAW'(1);
            if (w_rf_pop)
                r_rf_rptr <= r_rf_rptr + FAW'(1);
            case ({w_rf_push, w_rf_pop})
                2'b10:   r_rf_cnt <= r_rf_cnt + CW'(1);
                2'b01:   r_rf_cnt <= r_rf_cnt - CW'(1);
                default: r_rf_cnt <= r_rf_cnt;
            endcase
        end
    end

    always_ff @(posedge ctrl_clk) begin
        if (w_rf_push)
            r_rf_mem[r_rf_wptr] <= r_mem_q_p1;
    end

    // ---- stage p2: output register ----
    always_ff @(posedge ctrl_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovalid <= 1'b0;
            r_odata  <= '0;
        end else begin
            r_ovalid <= w_rf_pop;
            if (w_rf_pop)
                r_odata <= w_rf_q;
        end
    end

    assign oData              = r_odata;
    assign oValid             = r_ovalid;
    assign read_empty_rdfifo  = w_rf_empty;
    assign write_full_wrfifo  = w_wf_full;
    assign write_fifo_wrusedw = r_wf_cnt;
    assign write_fifo_rdusedw = r_wf_cnt;
    assign read_fifo_wrusedw  = r_rf_cnt;
    assign read_fifo_rdusedw  = r_rf_cnt;

endmodule

// File: tb/tb_frame_bus.sv
// Directed bench for frame_bus: store/replay order, read latency, write-FIFO
// overflow while a long replay holds the controller, and mid-burst reset.
module tb_frame_bus;

    logic        clk;
    logic        rst_n;
    logic [31:0] i_data;
    logic        i_valid;
    logic        rd_init;
    logic [31:0] o_data;
    logic        o_valid;
    logic        rf_empty;
    logic        wf_full;
    logic [8:0]  wf_wrusedw;
    logic [8:0]  wf_rdusedw;
    logic [8:0]  rf_wrusedw;
    logic [8:0]  rf_rdusedw;

    frame_bus #(.DATA_W(32), .FIFO_DEPTH(256), .MEM_DEPTH(1024)) dut (
        .ctrl_clk           (clk),
        .reset_n            (rst_n),
        .iData              (i_data),
        .iValid             (i_valid),
        .read_init          (rd_init),
        .oData              (o_data),
        .oValid             (o_valid),
        .read_empty_rdfifo  (rf_empty),
        .write_full_wrfifo  (wf_full),
        .write_fifo_wrusedw (wf_wrusedw),
        .write_fifo_rdusedw (wf_rdusedw),
        .read_fifo_wrusedw  (rf_wrusedw),
        .read_fifo_rdusedw  (rf_rdusedw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          first_cyc = -1;
    int          full_bad = 0;
    int          usedw_bad = 0;
    int          saw_full = 0;
    int          max_wf = 0;
    logic [31:0] got[$];
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_chk++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got_v, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (o_valid) begin
            got.push_back(o_data);
            if (first_cyc < 0) first_cyc = cyc;
        end
        if (wf_full !== (wf_wrusedw == 9'd256)) full_bad++;
        if ((wf_wrusedw !== wf_rdusedw) || (rf_wrusedw !== rf_rdusedw)) usedw_bad++;
        if (wf_full) saw_full = 1;
        if (int'(wf_wrusedw) > max_wf) max_wf = int'(wf_wrusedw);
    endtask

    task automatic write_words(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            i_valid = 1'b1;
            i_data  = 32'(base + i);
            tick();
        end
        i_valid = 1'b0;
    endtask

    task automatic push_exp(input int base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(32'(base + i));
    endtask

    // Raise read_init for 'hold' cycles, then keep collecting for 'budget' cycles
    task automatic do_read(input int hold, input int budget, output int lat);
        int start;
        got.delete();
        first_cyc = -1;
        start = cyc;
        rd_init = 1'b1;
        repeat (hold) tick();
        rd_init = 1'b0;
        repeat (budget) tick();
        lat = (first_cyc < 0) ? -1 : first_cyc - start;
    endtask

    task automatic cmp_words(input string tag);
        chk({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk(tag, 64'(got[i]), 64'(exp_q[i]));
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ovalid"}, 64'(o_valid), 64'd0);
        chk({tag, "_rf_empty"}, 64'(rf_empty), 64'd1);
        chk({tag, "_wf_full"}, 64'(wf_full), 64'd0);
        chk({tag, "_wf_used"}, 64'(wf_wrusedw), 64'd0);
        chk({tag, "_wf_rdused"}, 64'(wf_rdusedw), 64'd0);
        chk({tag, "_rf_used"}, 64'(rf_wrusedw), 64'd0);
        chk({tag, "_rf_rdused"}, 64'(rf_rdusedw), 64'd0);
    endtask

    initial begin
        int lat;
        rst_n   = 1'b0;
        i_data  = '0;
        i_valid = 1'b0;
        rd_init = 1'b0;
        #23;
        chk_idle_outputs("reset");
        chk("reset_odata", 64'(o_data), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick();

        // replay request with nothing stored
        do_read(2, 30, lat);
        chk("empty_read_count", 64'(got.size()), 64'd0);

        // 16 words, long read_init pulse
        write_words(1, 16);
        repeat (6) tick();
        push_exp(1, 16);
        do_read(24, 12, lat);
        cmp_words("read1");
        chk("read1_lat_le8", 64'((lat >= 0) && (lat <= 8)), 64'd1);
        chk("read1_rf_empty_after", 64'(rf_empty), 64'd1);

        // replay again without new writes
        do_read(2, 30, lat);
        cmp_words("read2");
        chk("read2_lat_le8", 64'((lat >= 0) && (lat <= 8)), 64'd1);

        // 300 words while idle drain at full rate: never full
        saw_full = 0;
        max_wf = 0;
        write_words(1001, 300);
        repeat (8) tick();
        chk("burst_no_full", 64'(saw_full), 64'd0);
        chk("burst_drained", 64'(wf_wrusedw), 64'd0);
        push_exp(1001, 300);

        // 300 words during a 316-word replay: 256 fit, the rest are dropped
        got.delete();
        first_cyc = -1;
        saw_full = 0;
        max_wf = 0;
        rd_init = 1'b1;
        repeat (2) tick();
        rd_init = 1'b0;
        repeat (2) tick();
        write_words(2001, 300);
        repeat (100) tick();
        cmp_words("read3");
        chk("overflow_saw_full", 64'(saw_full), 64'd1);
        chk("overflow_max_occ", 64'(max_wf), 64'd256);
        for (int k = 0; k < 600 && wf_wrusedw != 0; k++) tick();
        chk("overflow_drained", 64'(wf_wrusedw), 64'd0);
        repeat (4) tick();
        push_exp(2001, 256);
        do_read(2, 640, lat);
        cmp_words("read4");
        chk("full_flag_consistent", 64'(full_bad), 64'd0);
        chk("usedw_pairs_equal", 64'(usedw_bad), 64'd0);

        // reset in the middle of a replay burst
        got.delete();
        rd_init = 1'b1;
        repeat (2) tick();
        rd_init = 1'b0;
        for (int k = 0; k < 200 && got.size() < 20; k++) tick();
        chk("midreset_burst_started", 64'(got.size() >= 20), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) tick();
        do_read(2, 30, lat);
        chk("post_reset_read_count", 64'(got.size()), 64'd0);

        // controller back in IDLE: fresh words land from address 0
        write_words(5, 3);
        repeat (6) tick();
        exp_q.delete();
        push_exp(5, 3);
        do_read(2, 30, lat);
        cmp_words("read5");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
